seg_drv: RTL and testbench

- Serial driver for an 8-digit seven-segment display built from a chain of external 8-bit serial-in shift registers.
- On a `start` pulse it latches a 32-bit word of eight hex digits and encodes each digit to an active-low segment byte.
- It then shifts the resulting 64-bit frame out on `sout`/`sclk`, with `EN` signalling a stable, complete frame.
- Sits between counter/display logic (e.g. the clock block) and the board's segment pins.

---
 rtl/seg_drv.sv | 105 ++++++++++
 tb/tb_seg_drv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_drv.sv
// Serial driver for an 8-digit seven-segment display behind a chain of 8-bit shift registers.
// Latches eight hex digits on start, encodes them active-low and shifts a 64-bit frame out MSB first.
module seg_drv #(
    parameter int DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] num,
    output logic        sclk,
    output logic        sout,
    output logic        EN
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state;
    logic [63:0]   shreg;
    logic [63:0]   frame;
    logic [5:0]    bit_cnt;
    logic [CW-1:0] div_cnt;

    // Segment byte is {dp,g,f,e,d,c,b,a}, active low, decimal point always off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        frame = '0;
        for (int k = 0; k < 8; k++) begin
            frame[8*k +: 8] = seg7(num[4*k +: 4]);
        end
    end

    // The frame MSB drives the pin directly, so sout only moves when the register shifts.
    assign sout = shreg[63];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk    <= 1'b0;
            EN      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk <= 1'b0;
                    if (start) begin
                        shreg   <= frame;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        EN      <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_cnt == CW'(DIV - 1)) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            // Last bit is left in place so sout holds it while idle.
                            if (bit_cnt == 6'd63) begin
                                state <= IDLE;
                                EN    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                shreg   <= {shreg[62:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_drv.sv
// Self-checking bench for seg_drv: captures sout on every sclk rise and
// compares completed 64-bit frames against a scoreboard of expected frames.
module tb_seg_drv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] num;
    logic        sclk;
    logic        sout;
    logic        EN;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int load_cyc   = 0;
    int rise_cnt   = 0;
    int cap_cnt    = 0;
    int frames_ok  = 0;
    logic [63:0] cap;
    logic        sclk_q = 1'b0;
    logic [63:0] exp_q[$];

    seg_drv #(.DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .num   (num),
        .sclk  (sclk),
        .sout  (sout),
        .EN    (EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Independent reference table for the active-low segment encoding.
    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        logic [7:0] tab [16];
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tab[d];
    endfunction

    function automatic logic [63:0] exp_frame(input logic [31:0] n);
        logic [63:0] f;
        f = '0;
        for (int k = 7; k >= 0; k--) begin
            f = {f[55:0], ref_seg(n[4*k +: 4])};
        end
        return f;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Sampled on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (reset) begin
            cap_cnt = 0;
        end else if (sclk && !sclk_q) begin
            rise_cnt++;
            cap = {cap[62:0], sout};
            cap_cnt++;
            if (cap_cnt == 64) begin
                cap_cnt = 0;
                if (exp_q.size() == 0) begin
                    check_output("frame_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_output("frame_bits", cap, exp_q.pop_front());
                    frames_ok++;
                end
            end
        end
        sclk_q = sclk;
    end

    task automatic apply_stimulus(input logic [31:0] n);
        num   = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        load_cyc = cyc;
        exp_q.push_back(exp_frame(n));
        check_output("load_en", 64'(EN), 64'd0);
        check_output("load_sclk", 64'(sclk), 64'd0);
        check_output("load_sout", 64'(sout), 64'(exp_frame(n) >> 63));
    endtask

    task automatic wait_en(output int lat);
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (EN) begin
                lat = cyc - load_cyc;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int target, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (rise_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        check_output(tag, 64'(ok), 64'd1);
    endtask

    task automatic idle_check(input int n, input logic en_exp, input string tag);
        int base;
        int bad;
        base = rise_cnt;
        bad  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sclk !== 1'b0 || EN !== en_exp) bad++;
        end
        check_output({tag, "_levels"}, 64'(bad), 64'd0);
        check_output({tag, "_no_sclk"}, 64'(rise_cnt - base), 64'd0);
    endtask

    initial begin
        int lat;
        int base;
        reset = 1'b1;
        start = 1'b0;
        num   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("rst_sclk", 64'(sclk), 64'd0);
        check_output("rst_sout", 64'(sout), 64'd0);
        check_output("rst_en", 64'(EN), 64'd0);
        idle_check(20, 1'b0, "idle");
        check_output("idle_sout", 64'(sout), 64'd0);

        $display("[TB] single frame 0123_4567");
        base = rise_cnt;
        apply_stimulus(32'h0123_4567);
        wait_en(lat);
        check_output("frame1_latency", 64'(lat), 64'd256);
        check_output("frame1_rises", 64'(rise_cnt - base), 64'd64);
        check_output("frame1_drained", 64'(exp_q.size()), 64'd0);
        check_output("frame1_bytes", exp_frame(32'h0123_4567), 64'hC0F9_A4B0_9992_82F8);

        $display("[TB] encoding frame 89AB_CDEF");
        repeat (3) @(posedge clk);
        #1;
        check_output("en_held_idle", 64'(EN), 64'd1);
        base = rise_cnt;
        apply_stimulus(32'h89AB_CDEF);
        wait_en(lat);
        check_output("frame2_latency", 64'(lat), 64'd256);
        check_output("frame2_rises", 64'(rise_cnt - base), 64'd64);
        check_output("frame2_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] start and num change during shift");
        base = rise_cnt;
        apply_stimulus(32'h0000_0000);
        wait_rises(base + 20, "reach_bit20");
        num   = 32'hFFFF_FFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        num = 32'h1234_5678;
        wait_en(lat);
        check_output("frame3_latency", 64'(lat), 64'd256);
        check_output("frame3_rises", 64'(rise_cnt - base), 64'd64);
        check_output("frame3_drained", 64'(exp_q.size()), 64'd0);
        idle_check(20, 1'b1, "no_second_frame");

        $display("[TB] reset mid-frame");
        base = rise_cnt;
        apply_stimulus(32'h89AB_CDEF);
        wait_rises(base + 30, "reach_bit30");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_sclk", 64'(sclk), 64'd0);
        check_output("midrst_sout", 64'(sout), 64'd0);
        check_output("midrst_en", 64'(EN), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        idle_check(20, 1'b0, "after_reset");

        $display("[TB] back-to-back with start held");
        num   = 32'h0123_4567;
        start = 1'b1;
        exp_q.push_back(exp_frame(32'h0123_4567));
        exp_q.push_back(exp_frame(32'h0123_4567));
        @(posedge clk);
        #1;
        load_cyc = cyc;
        wait_en(lat);
        check_output("b2b1_latency", 64'(lat), 64'd256);
        @(posedge clk);
        #1;
        check_output("b2b_en_one_cycle", 64'(EN), 64'd0);
        load_cyc = cyc;
        wait_en(lat);
        check_output("b2b2_latency", 64'(lat), 64'd256);
        check_output("b2b_drained", 64'(exp_q.size()), 64'd0);
        reset = 1'b1;
        base  = rise_cnt;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_start_en", 64'(EN), 64'd0);
        check_output("rst_start_sclk", 64'(sclk), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        idle_check(20, 1'b0, "rst_start_idle");
        check_output("rst_start_rises", 64'(rise_cnt - base), 64'd0);
        check_output("frames_seen", 64'(frames_ok), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
